// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Burst front-end for a single-port RAM with a combinational read port
// (dout = mem[addr]). It accepts burst commands and generates every RAM
// addr/din/wr/select cycle. Write bursts stream beats into the RAM. Read
// bursts stream beats out of it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Ready is a registered output and never depends
// combinationally on valid. rdata_valid has no backpressure.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_len
//                 burst command; beats = cmd_len + 1
//   wdata/wdata_valid/wdata_ready
//                 write beat stream
//   rdata/rdata_valid
//                 read beat stream
//   burst_done    one-cycle pulse at burst completion
//   busy          high whenever the FSM is not idle
//   ram_addr/ram_din/ram_wr/ram_select/ram_dout
//                 RAM side
//   dbg_state     current FSM state (0=IDLE 1=WRITE 2=READ 3=FLUSH)
//
// All outputs are registered.
module ram_burst_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              burst_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr,
  output logic              ram_select,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  cur_addr, cur_addr_n;
  logic [LEN_W-1:0]   beats_left, beats_left_n;

  logic               cmd_ready_n, wdata_ready_n, rdata_valid_n;
  logic               burst_done_n, busy_n, ram_wr_n, ram_select_n;
  logic [DATA_W-1:0]  rdata_n, ram_din_n;
  logic [ADDR_W-1:0]  ram_addr_n;
  logic               read_in_flight;

  // A read address presented this cycle returns its data on ram_dout in
  // this same cycle. That data is captured at the closing edge, which gives
  // one cycle of latency on rdata.
  assign read_in_flight = ram_select & ~ram_wr;

  assign dbg_state = state;

  always_comb begin
    state_n       = state;
    cur_addr_n    = cur_addr;
    beats_left_n  = beats_left;
    cmd_ready_n   = 1'b0;
    wdata_ready_n = 1'b0;
    burst_done_n  = 1'b0;
    ram_addr_n    = ram_addr;
    ram_din_n     = ram_din;
    ram_wr_n      = 1'b0;
    ram_select_n  = 1'b0;
    rdata_valid_n = read_in_flight;
    rdata_n       = read_in_flight ? ram_dout : rdata;

    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cur_addr_n   = cmd_addr;
          beats_left_n = cmd_len;
          cmd_ready_n  = 1'b0;
          if (cmd_write) begin
            state_n       = WRITE;
            wdata_ready_n = 1'b1;
          end else begin
            state_n = READ;
          end
        end
      end

      WRITE: begin
        wdata_ready_n = 1'b1;
        if (wdata_valid && wdata_ready) begin
          ram_select_n = 1'b1;
          ram_wr_n     = 1'b1;
          ram_addr_n   = cur_addr;
          ram_din_n    = wdata;
          cur_addr_n   = cur_addr + 1'b1;
          beats_left_n = beats_left - 1'b1;
          if (beats_left == '0) begin
            // The final strobe, done pulse and return to idle all take
            // effect at the same edge.
            wdata_ready_n = 1'b0;
            burst_done_n  = 1'b1;
            cmd_ready_n   = 1'b1;
            state_n       = IDLE;
          end
        end
      end

      READ: begin
        ram_select_n = 1'b1;
        ram_addr_n   = cur_addr;
        cur_addr_n   = cur_addr + 1'b1;
        beats_left_n = beats_left - 1'b1;
        if (beats_left == '0) begin
          state_n = FLUSH;
        end
      end

      FLUSH: begin
        // The last address is on the bus during this state. Its data is
        // captured at the closing edge together with the done pulse.
        burst_done_n = 1'b1;
        cmd_ready_n  = 1'b1;
        state_n      = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      beats_left  <= '0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      burst_done  <= 1'b0;
      busy        <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_wr      <= 1'b0;
      ram_select  <= 1'b0;
    end else begin
      state       <= state_n;
      cur_addr    <= cur_addr_n;
      beats_left  <= beats_left_n;
      cmd_ready   <= cmd_ready_n;
      wdata_ready <= wdata_ready_n;
      rdata       <= rdata_n;
      rdata_valid <= rdata_valid_n;
      burst_done  <= burst_done_n;
      busy        <= busy_n;
      ram_addr    <= ram_addr_n;
      ram_din     <= ram_din_n;
      ram_wr      <= ram_wr_n;
      ram_select  <= ram_select_n;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [7:0] wdata = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       burst_done;
  logic       busy;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_wr;
  logic       ram_select;
  logic [7:0] ram_dout;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // RAM attached to the controller.
  logic [7:0] mem [1024];
  // Reference contents: what the RAM should hold after every burst.
  logic [7:0] ref_mem [1024];
  // Beat data for the next write burst.
  logic [7:0] wbuf [256];
  // Expected read data, in beat order, for the current read burst.
  logic [7:0] exp_q[$];

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .burst_done(burst_done), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr(ram_wr),
    .ram_select(ram_select), .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // ---------------- clock / ram model / watchdog ----------------
  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_select && ram_wr) mem[ram_addr] <= ram_din;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] wrap_addr(input logic [9:0] base, input int off);
    return 10'((int'(base) + off) % 1024);
  endfunction

  // Wait (bounded) for cmd_ready, then present one command for one edge.
  task automatic send_cmd(input logic w, input logic [9:0] a, input logic [7:0] l);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("accept_busy_ready", {busy, cmd_ready}, 2'b10);
  endtask

  // Data phase of a write burst, starting right after the accept edge.
  // mode 0: back-to-back, 1: valid dropped every 3rd cycle, 2: random gaps.
  task automatic write_phase(input logic [9:0] a, input int len, input int mode);
    int k;
    int cyc;
    logic v;
    k = 0;
    cyc = 0;
    while (k <= len && cyc < 2000) begin
      v = 1'b1;
      if (mode == 1 && (cyc % 3) == 2) v = 1'b0;
      if (mode == 2 && $urandom_range(0, 3) == 0) v = 1'b0;
      chk("wr_wdata_ready", wdata_ready, 1);
      chk("wr_cmd_ready_low", cmd_ready, 0);
      wdata_valid = v;
      wdata = v ? wbuf[k] : 8'($urandom);
      tick();
      if (v) begin
        chk("wr_strobe_sel_wr", {ram_select, ram_wr}, 2'b11);
        chk("wr_addr", ram_addr, wrap_addr(a, k));
        chk("wr_din", ram_din, wbuf[k]);
        chk("wr_done", burst_done, (k == len));
        ref_mem[wrap_addr(a, k)] = wbuf[k];
        if (k == len)
          chk("wr_end_ready_busy", {wdata_ready, busy, cmd_ready}, 3'b001);
        k++;
      end else begin
        chk("wr_gap_sel_wr", {ram_select, ram_wr}, 2'b00);
        chk("wr_gap_done", burst_done, 0);
      end
      cyc++;
    end
    wdata_valid = 1'b0;
    if (k <= len) chk("wr_timeout", k, len + 1);
  endtask

  // Address/data phase of a read burst, starting right after the accept edge.
  task automatic read_phase(input logic [9:0] a, input int len);
    logic [7:0] e;
    exp_q.delete();
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[wrap_addr(a, i)]);
    for (int t = 1; t <= len + 2; t++) begin
      tick();
      if (t <= len + 1) begin
        chk("rd_sel_wr", {ram_select, ram_wr}, 2'b10);
        chk("rd_addr", ram_addr, wrap_addr(a, t - 1));
      end else begin
        chk("rd_flush_sel", ram_select, 0);
      end
      if (t >= 2) begin
        chk("rd_valid", rdata_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        chk("rd_data", rdata, e);
      end else begin
        chk("rd_valid_early", rdata_valid, 0);
      end
      chk("rd_done", burst_done, (t == len + 2));
      chk("rd_busy", busy, (t <= len + 1));
    end
  endtask

  task automatic check_idle(input string tag);
    tick();
    chk(tag, {cmd_ready, busy, burst_done, rdata_valid, ram_select, ram_wr, wdata_ready},
        7'b1000000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] ra;
    int rl;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // 1: reset
    tick(); tick(); tick();
    chk("reset_outputs",
        {cmd_ready, wdata_ready, rdata, rdata_valid, burst_done, busy,
         ram_addr, ram_din, ram_wr, ram_select, dbg_state}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready_busy", {cmd_ready, busy}, 2'b10);

    // wdata_valid while idle causes no access
    wdata_valid = 1'b1;
    wdata = 8'hFF;
    tick(); tick();
    chk("idle_wdata_no_access", {ram_select, ram_wr, wdata_ready, busy}, 4'b0000);
    wdata_valid = 1'b0;

    // 2: write across the wrap point
    for (int k = 0; k < 4; k++) wbuf[k] = 8'hA0 + 8'(k);
    send_cmd(1'b1, 10'h3FE, 8'd3);
    write_phase(10'h3FE, 3, 0);
    check_idle("after_wr_wrap");

    // 3: read it back
    send_cmd(1'b0, 10'h3FE, 8'd3);
    read_phase(10'h3FE, 3);
    check_idle("after_rd_wrap");

    // 4: 256-beat write with gaps, then readback
    for (int k = 0; k < 256; k++) wbuf[k] = 8'((k * 2) % 256);
    send_cmd(1'b1, 10'h000, 8'd255);
    write_phase(10'h000, 255, 1);
    check_idle("after_wr_long");
    send_cmd(1'b0, 10'h000, 8'd255);
    read_phase(10'h000, 255);
    check_idle("after_rd_long");

    // 5: cmd_valid held through a busy burst
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    cmd_write = 1'b1; cmd_addr = 10'h200; cmd_len = 8'd2; cmd_valid = 1'b1;
    tick();
    chk("hold_accept_busy", busy, 1);
    cmd_write = 1'b0; cmd_addr = 10'h1FF; cmd_len = 8'd3;
    write_phase(10'h200, 2, 0);
    chk("hold_ready_at_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_second_accept", {busy, cmd_ready}, 2'b10);
    read_phase(10'h1FF, 3);
    check_idle("after_hold");

    // randomized write/readback bursts
    for (int r = 0; r < 4; r++) begin
      ra = 10'($urandom_range(0, 1023));
      rl = $urandom_range(0, 24);
      for (int k = 0; k <= rl; k++) wbuf[k] = 8'($urandom);
      send_cmd(1'b1, ra, 8'(rl));
      write_phase(ra, rl, 2);
      send_cmd(1'b0, ra, 8'(rl));
      read_phase(ra, rl);
    end
    check_idle("after_random");

    // 6: reset during beat 5 of a 16-beat read
    send_cmd(1'b0, 10'h000, 8'd15);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t >= 2) chk("mid_rd_data", rdata, ref_mem[t - 2]);
      chk("mid_rd_done", burst_done, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs",
        {cmd_ready, wdata_ready, rdata, rdata_valid, burst_done, busy,
         ram_addr, ram_din, ram_wr, ram_select, dbg_state}, 64'd0);
    for (int t = 0; t < 2; t++) begin
      tick();
      chk("in_reset_quiet", {burst_done, rdata_valid, ram_select, busy}, 4'b0000);
    end
    rst_n = 1'b1;
    tick();
    chk("post_mid_reset", {cmd_ready, busy, burst_done}, 3'b100);
    send_cmd(1'b0, 10'h3FE, 8'd3);
    read_phase(10'h3FE, 3);
    check_idle("after_mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
